// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : ALU opcodes, arbiter FSM states and the opcode legality helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] ctrl);
    case (ctrl)
      ADD, SUB, AND, OR, SLT: is_legal_op = 1'b1;
      default:                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module : alu
// Brief  : Existing single-cycle 32-bit ALU (ADD/SUB/AND/OR/signed SLT).
// Rev    : 1.0
// ============================================================================
`default_nettype none

import alu_pkg::*;

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (ctrl)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      // Signed compare avoids the overflow trap of looking at the sign of a-b.
      SLT:     y = {31'd0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin picker; search begins one past last grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  int   w_k;
  logic w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_k = (int'(last_grant) + i) % N_REQ;
      if (!w_found && valid[w_k]) begin
        w_found    = 1'b1;
        grant[w_k] = 1'b1;
        grant_idx  = ID_W'(w_k);
      end
    end
  end

  assign any = |valid;

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module : alu_share_arbiter
// Brief  : Round-robin sharing of one registered single-cycle ALU among N_REQ
//          requesters. Optional macro: ALU_ILLEGAL_OP_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

import alu_pkg::*;

module alu_share_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [N_REQ-1:0]       i_ReqValid,
  input  logic [N_REQ-1:0][31:0] i_ReqSrcA,
  input  logic [N_REQ-1:0][31:0] i_ReqSrcB,
  input  logic [N_REQ-1:0][2:0]  i_ReqCtrl,
  output logic [N_REQ-1:0]       o_ReqReady,
  output logic                   o_RspValid,
  input  logic                   i_RspReady,
  output logic [ID_W-1:0]        o_RspId,
  output logic [31:0]            o_RspResult,
  output logic                   o_RspZero,
  output logic                   o_RspErr
);

  state_e            r_state, w_next;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       r_src_a, r_src_b;
  logic [2:0]        r_ctrl;
  logic [31:0]       r_result;
  logic              r_zero;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_any;
  logic              w_accept;
  logic [31:0]       w_alu_y;
  logic              w_alu_zero;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid      (i_ReqValid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any        (w_any)
  );

  alu u_alu (
    .a    (r_src_a),
    .b    (r_src_b),
    .ctrl (r_ctrl),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  assign w_accept = (r_state == IDLE) && w_any;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (i_RspReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_ReqReady = (r_state == IDLE) ? w_grant : '0;
    o_RspValid = (r_state == RESP);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_last_grant <= ID_W'(N_REQ - 1);
      r_id         <= '0;
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_ctrl       <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_id         <= w_grant_idx;
        r_src_a      <= i_ReqSrcA[w_grant_idx];
        r_src_b      <= i_ReqSrcB[w_grant_idx];
        r_ctrl       <= i_ReqCtrl[w_grant_idx];
      end
      if (r_state == EXEC) begin
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        if (is_legal_op(r_ctrl)) begin
          r_result <= w_alu_y;
          r_zero   <= w_alu_zero;
        end else begin
          r_result <= '0;
          r_zero   <= 1'b1;
        end
`else
        r_result <= w_alu_y;
        r_zero   <= w_alu_zero;
`endif
      end
    end
  end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic r_err;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)               r_err <= 1'b0;
    else if (r_state == EXEC)  r_err <= ~is_legal_op(r_ctrl);
  end

  assign o_RspErr = r_err;
`else
  assign o_RspErr = 1'b0;
`endif

  // The id register is only rewritten on accept, which cannot happen in RESP.
  assign o_RspId     = r_id;
  assign o_RspResult = r_result;
  assign o_RspZero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module : tb_alu_share_arbiter
// Brief  : Directed + randomized bench against a transaction-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       valid = '0;
  logic [N-1:0][31:0] src_a = '0;
  logic [N-1:0][31:0] src_b = '0;
  logic [N-1:0][2:0]  ctrl = '0;
  logic               rsp_ready = 1'b0;
  logic [N-1:0]       o_ReqReady;
  logic               o_RspValid;
  logic [IW-1:0]      o_RspId;
  logic [31:0]        o_RspResult;
  logic               o_RspZero;
  logic               o_RspErr;

  int total = 0;
  int bad   = 0;

  // Model: 0 = free, 1 = computing, 2 = response pending
  int          m_phase = 0;
  int          m_last  = N - 1;
  int          m_id    = 0;
  logic [31:0] m_res   = '0;
  logic        m_zero  = 1'b0;
  logic        m_err   = 1'b0;
  int          cyc     = 0;
  logic [N-1:0] s_ready;
  int          grant_log[$];
  int          accept_cyc[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(N)) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_ReqValid  (valid),
    .i_ReqSrcA   (src_a),
    .i_ReqSrcB   (src_b),
    .i_ReqCtrl   (ctrl),
    .o_ReqReady  (o_ReqReady),
    .o_RspValid  (o_RspValid),
    .i_RspReady  (rsp_ready),
    .o_RspId     (o_RspId),
    .o_RspResult (o_RspResult),
    .o_RspZero   (o_RspZero),
    .o_RspErr    (o_RspErr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output logic [31:0] res, output logic z, output logic err);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    err = 1'b0;
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b101:  res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin res = 32'd0; err = 1'b1; end
    endcase
`ifndef ALU_ILLEGAL_OP_CHECK_EN
    err = 1'b0;
`endif
    z = (res == 32'd0);
  endtask

  function automatic logic [2:0] pick_ctrl();
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic [2:0] ops[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7};
    return ops[$urandom_range(0, 7)];
`else
    logic [2:0] ops[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    return ops[$urandom_range(0, 4)];
`endif
  endfunction

  // Entered with clk low and inputs set; checks, advances model, ends at next negedge.
  task automatic do_cycle();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = rr_winner(valid, m_last);
    exp_rdy = '0;
    if (m_phase == 0 && w >= 0) exp_rdy[w] = 1'b1;
    check("ready", o_ReqReady, exp_rdy);
    check("rsp_valid", o_RspValid, m_phase == 2);
    if (m_phase == 2) begin
      check("rsp_id", o_RspId, m_id);
      check("rsp_result", o_RspResult, m_res);
      check("rsp_zero", o_RspZero, m_zero);
      check("rsp_err", o_RspErr, m_err);
    end
    s_ready = o_ReqReady;
    case (m_phase)
      0: if (w >= 0) begin
           m_last = w;
           m_id   = w;
           ref_alu(src_a[w], src_b[w], ctrl[w], m_res, m_zero, m_err);
           m_phase = 1;
           grant_log.push_back(w);
           accept_cyc.push_back(cyc);
         end
      1: m_phase = 2;
      default: if (rsp_ready) m_phase = 0;
    endcase
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    valid = '0;
    rst   = 1'b1;
    #1;
    check("rst_ready", o_ReqReady, 0);
    check("rst_rspvalid", o_RspValid, 0);
    check("rst_id", o_RspId, 0);
    check("rst_result", o_RspResult, 0);
    check("rst_zero", o_RspZero, 0);
    check("rst_err", o_RspErr, 0);
    m_phase = 0;
    m_last  = N - 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic directed(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] er, input logic ez, input logic ee);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    valid = onehot;
    src_a[idx] = a;
    src_b[idx] = b;
    ctrl[idx] = op;
    rsp_ready = 1'b0;
    do_cycle();
    check({tag, "_ready"}, s_ready, onehot);
    valid = '0;
    do_cycle();
    #1;
    check({tag, "_valid"}, o_RspValid, 1);
    check({tag, "_id"}, o_RspId, idx);
    check({tag, "_result"}, o_RspResult, er);
    check({tag, "_zero"}, o_RspZero, ez);
    check({tag, "_err"}, o_RspErr, ee);
    rsp_ready = 1'b1;
    do_cycle();
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    directed("add", 1, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
    directed("subz", 3, 32'h10, 32'h10, 3'b001, 32'd0, 1'b1, 1'b0);
    directed("slt", 0, 32'h8000_0000, 32'h1, 3'b101, 32'd1, 1'b0, 1'b0);
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    directed("illegal", 2, 32'h1234, 32'h5678, 3'b111, 32'd0, 1'b1, 1'b1);
`endif

    // Backpressure: hold the response for 5 cycles while everyone requests.
    valid = 4'b0100;
    src_a[2] = 32'd1; src_b[2] = 32'd2; ctrl[2] = 3'b000;
    rsp_ready = 1'b0;
    do_cycle();
    valid = '0;
    do_cycle();
    valid = '1;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      check("bp_ready", s_ready, 0);
    end
    rsp_ready = 1'b1;
    do_cycle();
    do_cycle();
    check("bp_release", s_ready != 0, 1);
    valid = '0;
    rsp_ready = 1'b1;
    do_cycle();
    do_cycle();
    do_cycle();

    // Reset while a transaction is in EXEC.
    valid = 4'b0100;
    ctrl[2] = 3'b001;
    do_cycle();
    apply_reset();

    // Round robin with all requesters continuously valid.
    for (int i = 0; i < N; i++) begin
      src_a[i] = $urandom; src_b[i] = $urandom; ctrl[i] = 3'b000;
    end
    valid = '1;
    rsp_ready = 1'b1;
    grant_log.delete();
    accept_cyc.delete();
    for (int i = 0; i < 15; i++) do_cycle();
    check("rr_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 1);
      check("rr_g2", grant_log[2], 2);
      check("rr_g3", grant_log[3], 3);
      check("rr_g4", grant_log[4], 0);
      for (int i = 1; i < 5; i++)
        check("rr_spacing", accept_cyc[i] - accept_cyc[i-1], 3);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      valid = N'($urandom);
      for (int r = 0; r < N; r++) begin
        src_a[r] = ($urandom_range(0, 3) == 0) ? 32'(r) : $urandom;
        src_b[r] = ($urandom_range(0, 3) == 0) ? 32'(r) : $urandom;
        ctrl[r]  = pick_ctrl();
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
